// File: rtl/bpsk_tx_scheduler.sv
// bpsk_tx_scheduler: round-robin sharing of one BPSK modulator between NREQ frame sources,
// with frame buffering, stale-Done filtering, inter-frame gap and timeout recovery.
module bpsk_tx_scheduler #(
    parameter int NREQ         = 2,
    parameter int GAP_CYCLES   = 64,
    parameter int LOAD_TIMEOUT = 256,
    parameter int TX_TIMEOUT   = 600000,
    parameter int RST_CYCLES   = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [3*NREQ-1:0]   i_req_out_div,
    output logic [NREQ-1:0]     o_gnt,
    input  logic                i_wr_valid,
    input  logic [31:0]         i_wr_data,
    output logic                o_wr_ready,
    output logic [NREQ-1:0]     o_req_done,
    output logic [NREQ-1:0]     o_req_err,
    output logic                o_busy,
    output logic [31:0]         o_mod_data [0:15],
    output logic [2:0]          o_mod_out_div,
    output logic                o_mod_int,
    input  logic                i_mod_done,
    output logic                o_mod_reset_n
);
    localparam int IW   = $clog2(NREQ);
    localparam int M1   = GAP_CYCLES > LOAD_TIMEOUT ? GAP_CYCLES : LOAD_TIMEOUT;
    localparam int M2   = TX_TIMEOUT > RST_CYCLES ? TX_TIMEOUT : RST_CYCLES;
    localparam int TW   = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT, S_RST, S_GAP} state_t;

    state_t            r_state, w_state_nxt;
    logic [IW-1:0]     r_last, w_gidx;
    logic [IW:0]       w_sum;
    logic              w_found;
    logic [3:0]        r_wcnt;
    logic [TW-1:0]     r_tmr;
    logic [2:0]        w_divs [NREQ];
    logic              w_accept, w_abort, w_done, w_tx_to;
    logic [NREQ-1:0]   w_cur, w_gnt_nxt, w_done_nxt, w_err_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_div
        assign w_divs[i] = i_req_out_div[3*i +: 3];
    end

    // first pending requester after the last one served, wrapping around
    always_comb begin
        w_gidx  = r_last;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
            if (!w_found && i_req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[IW-1:0];
            end
        end
    end

    assign w_cur    = NREQ'(1) << r_last;
    assign w_accept = r_state == S_LOAD && i_wr_valid && o_wr_ready;
    assign w_abort  = r_state == S_LOAD &&
                      (~|(i_req & o_gnt) || (!w_accept && r_tmr == TW'(LOAD_TIMEOUT-1)));
    assign w_done   = r_state == S_WAIT && i_mod_done;
    // a Done in the timeout cycle still counts as a successful frame
    assign w_tx_to  = (r_state == S_ARM || r_state == S_WAIT) && !w_done &&
                      r_tmr == TW'(TX_TIMEOUT-1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_found ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = w_abort ? S_GAP : (w_accept && r_wcnt == 4'd15) ? S_ARM : S_LOAD;
            S_ARM:   w_state_nxt = w_tx_to ? S_RST : !i_mod_done ? S_WAIT : S_ARM;
            S_WAIT:  w_state_nxt = w_done ? S_GAP : w_tx_to ? S_RST : S_WAIT;
            S_RST:   w_state_nxt = r_tmr == TW'(RST_CYCLES-1) ? S_GAP : S_RST;
            S_GAP:   w_state_nxt = r_tmr == TW'(GAP_CYCLES-1) ? S_IDLE : S_GAP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt  = w_state_nxt != S_LOAD ? '0 : r_state == S_IDLE ? NREQ'(1) << w_gidx : o_gnt;
        w_done_nxt = w_done ? w_cur : '0;
        w_err_nxt  = (w_abort || w_tx_to) ? w_cur : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_gnt         <= '0;
            o_wr_ready    <= 1'b0;
            o_req_done    <= '0;
            o_req_err     <= '0;
            o_busy        <= 1'b0;
            o_mod_int     <= 1'b0;
            o_mod_reset_n <= 1'b1;
            o_mod_out_div <= '0;
            r_last        <= IW'(NREQ-1);
            r_wcnt        <= '0;
            r_tmr         <= '0;
            for (int k = 0; k < 16; k++) o_mod_data[k] <= '0;
        end else begin
            o_gnt         <= w_gnt_nxt;
            o_wr_ready    <= w_state_nxt == S_LOAD;
            o_req_done    <= w_done_nxt;
            o_req_err     <= w_err_nxt;
            o_busy        <= w_state_nxt != S_IDLE;
            o_mod_int     <= w_state_nxt == S_ARM || w_state_nxt == S_WAIT;
            o_mod_reset_n <= w_state_nxt != S_RST;
            // the TX timer runs uninterrupted across ARM and WAIT_DONE
            r_tmr  <= ((w_state_nxt != r_state && !(r_state == S_ARM && w_state_nxt == S_WAIT)) || w_accept)
                      ? '0 : r_tmr + 1'b1;
            r_wcnt <= r_state == S_IDLE ? '0 : w_accept ? r_wcnt + 4'd1 : r_wcnt;
            if (r_state == S_IDLE && w_found) begin
                r_last        <= w_gidx;
                o_mod_out_div <= w_divs[w_gidx];
            end
            if (w_accept) o_mod_data[r_wcnt] <= i_wr_data;
        end
    end
endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// tb_bpsk_tx_scheduler: directed scenario tests for bpsk_tx_scheduler (TX_TIMEOUT shortened to 1000).
module tb_bpsk_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [5:0]  req_div = {3'd5, 3'd3};
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        done_drv = 1'b0;
    logic [1:0]  gnt, req_done, req_err;
    logic        wr_ready, busy, mod_int, mod_reset_n, mod_done;
    logic [31:0] mod_data [0:15];
    logic [2:0]  mod_div;
    logic [12:0] ctrl;
    int          checks = 0;
    int          errors = 0;

    // the modulator's Done output is DoneDrv gated by Int
    assign mod_done = done_drv & mod_int;
    assign ctrl = {gnt, wr_ready, req_done, req_err, busy, mod_int, mod_reset_n, mod_div};

    always #5 clk = ~clk;

    bpsk_tx_scheduler #(.NREQ(2), .GAP_CYCLES(64), .LOAD_TIMEOUT(256), .TX_TIMEOUT(1000), .RST_CYCLES(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_out_div(req_div), .o_gnt(gnt),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready), .o_req_done(req_done),
        .o_req_err(req_err), .o_busy(busy), .o_mod_data(mod_data), .o_mod_out_div(mod_div),
        .o_mod_int(mod_int), .i_mod_done(mod_done), .o_mod_reset_n(mod_reset_n)
    );

    task automatic load_words(input int n, input logic [31:0] base, input logic [1:0] g, output int gcnt);
        int k = 0;
        int guard = 0;
        logic acc;
        gcnt = 0;
        while (k < n && guard < 400) begin
            wr_valid = 1'b1;
            wr_data  = base + k;
            acc      = wr_ready;
            if (gnt == g) gcnt++;
            @(negedge clk);
            guard++;
            if (acc) k++;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl !== 13'h008) begin errors++; $display("FAIL reset_ctrl: got %h exp %h", ctrl, 13'h008); end
        for (int k = 0; k < 16; k++) if (mod_data[k] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_moddata: got %0d nonzero words exp 0", bad); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl !== 13'h008) begin errors++; $display("FAIL idle_ctrl: got %h exp %h", ctrl, 13'h008); end
    endtask

    task automatic test_single_frame;
        int gc, bad;
        req = 2'b01;
        wr_valid = 1'b1;
        wr_data = '0;
        @(negedge clk);
        checks++;
        if ({gnt, wr_ready, busy} !== 4'b0111) begin errors++; $display("FAIL sf_grant: got %b exp 0111", {gnt, wr_ready, busy}); end
        load_words(16, 32'h0, 2'b01, gc);
        req = 2'b00;
        checks++;
        if (gc != 16) begin errors++; $display("FAIL sf_gnt_len: got %0d exp 16", gc); end
        checks++;
        if ({gnt, wr_ready, mod_int} !== 4'b0001) begin errors++; $display("FAIL sf_arm: got %b exp 0001", {gnt, wr_ready, mod_int}); end
        bad = 0;
        for (int k = 0; k < 16; k++) if (mod_data[k] !== 32'(k)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sf_moddata: got %0d wrong words exp 0", bad); end
        checks++;
        if (mod_div !== 3'd3) begin errors++; $display("FAIL sf_outdiv: got %0d exp 3", mod_div); end
        bad = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (!mod_int || req_done != 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sf_hold_int: got %0d bad cycles exp 0", bad); end
        done_drv = 1'b1;
        @(negedge clk);
        checks++;
        if ({mod_int, req_done} !== 3'b001) begin errors++; $display("FAIL sf_done: got %b exp 001", {mod_int, req_done}); end
        done_drv = 1'b0;
        bad = 0;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (req_done != 2'b00 || mod_int) bad++;
            if (j == 63 && !busy) bad++;
            if (j == 64 && busy) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sf_gap: got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        int n, gc;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp = f[0] ? 2'b10 : 2'b01;
            n = 0;
            while (gnt == 2'b00 && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (gnt !== exp) begin errors++; $display("FAIL rr_order%0d: got %b exp %b", f, gnt, exp); end
            if (f > 0) begin
                checks++;
                if (n != 65) begin errors++; $display("FAIL rr_gap%0d: got %0d exp 65", f, n); end
            end
            load_words(16, 32'(f * 16), exp, gc);
            if (f == 3) req = 2'b00;
            repeat (5) @(negedge clk);
            done_drv = 1'b1;
            n = 0;
            while (req_done == 2'b00 && n < 20) begin
                @(negedge clk);
                n++;
            end
            done_drv = 1'b0;
            checks++;
            if (req_done !== exp) begin errors++; $display("FAIL rr_done%0d: got %b exp %b", f, req_done, exp); end
        end
        wait_idle(n);
    endtask

    task automatic test_stale_done;
        int gc, cnt, n;
        req = 2'b01;
        done_drv = 1'b1;
        @(negedge clk);
        load_words(16, 32'h200, 2'b01, gc);
        req = 2'b00;
        cnt = 0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (i == 20) done_drv = 1'b0;
            if (req_done != 2'b00 || !mod_int) cnt++;
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL stale_early: got %0d bad cycles exp 0", cnt); end
        done_drv = 1'b1;
        @(negedge clk);
        checks++;
        if ({mod_int, req_done} !== 3'b001) begin errors++; $display("FAIL stale_done500: got %b exp 001", {mod_int, req_done}); end
        done_drv = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_done != 2'b00) cnt++;
        end
        checks++;
        if (cnt != 0) begin errors++; $display("FAIL stale_extra: got %0d extra pulses exp 0", cnt); end
        wait_idle(n);
    endtask

    task automatic test_load_abort;
        int gc, bad, n;
        req = 2'b10;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL ab_grant: got %b exp 10", gnt); end
        load_words(5, 32'h100, 2'b10, gc);
        req = 2'b00;
        @(negedge clk);
        checks++;
        if ({req_err, gnt, wr_ready, mod_int, busy} !== 7'b1000001) begin
            errors++; $display("FAIL ab_reqdrop: got %b exp 1000001", {req_err, gnt, wr_ready, mod_int, busy});
        end
        bad = 0;
        for (int k = 0; k < 16; k++) if (mod_data[k] !== (k < 5 ? 32'h100 + 32'(k) : 32'h200 + 32'(k))) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ab_partial: got %0d wrong words exp 0", bad); end
        req = 2'b01;
        bad = 0;
        n = 0;
        while (gnt == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
            if (mod_int || req_err != 2'b00) bad++;
        end
        checks++;
        if (n != 65 || gnt !== 2'b01 || bad != 0) begin
            errors++; $display("FAIL ab_regrant: got n=%0d gnt=%b bad=%0d exp n=65 gnt=01 bad=0", n, gnt, bad);
        end
        load_words(3, 32'h300, 2'b01, gc);
        bad = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (mod_int || (i < 256 && req_err != 2'b00)) bad++;
        end
        checks++;
        if (bad != 0 || {req_err, gnt} !== 4'b0100) begin
            errors++; $display("FAIL ab_stall: got err=%b gnt=%b bad=%0d exp err=01 gnt=00 bad=0", req_err, gnt, bad);
        end
        req = 2'b00;
        wait_idle(n);
    endtask

    task automatic test_tx_timeout;
        int gc, bad, low, j;
        req = 2'b10;
        @(negedge clk);
        load_words(16, 32'h400, 2'b10, gc);
        req = 2'b00;
        bad = 0;
        for (int i = 1; i < 1000; i++) begin
            @(negedge clk);
            if (!mod_int || !mod_reset_n || req_err != 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL to_pre: got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        checks++;
        if ({mod_int, mod_reset_n, req_err} !== 4'b0010) begin
            errors++; $display("FAIL to_fire: got %b exp 0010", {mod_int, mod_reset_n, req_err});
        end
        low = 1;
        bad = 0;
        j = 0;
        while (busy && j < 200) begin
            @(negedge clk);
            j++;
            if (!mod_reset_n) low++;
            if (req_err != 2'b00 || mod_int) bad++;
        end
        checks++;
        if (low != 4 || j != 68 || bad != 0) begin
            errors++; $display("FAIL to_reset: got low=%0d idle_at=%0d bad=%0d exp low=4 idle_at=68 bad=0", low, j, bad);
        end
        req = 2'b01;
        @(negedge clk);
        load_words(16, 32'h500, 2'b01, gc);
        req = 2'b00;
        repeat (999) @(negedge clk);
        checks++;
        if (!mod_int) begin errors++; $display("FAIL tod_pre: got mod_int=%b exp 1", mod_int); end
        done_drv = 1'b1;
        @(negedge clk);
        done_drv = 1'b0;
        checks++;
        if ({mod_int, mod_reset_n, req_done, req_err} !== 6'b010100) begin
            errors++; $display("FAIL tod_done_wins: got %b exp 010100", {mod_int, mod_reset_n, req_done, req_err});
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!mod_reset_n || req_err != 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL tod_no_reset: got %0d bad cycles exp 0", bad); end
        wait_idle(j);
    endtask

    task automatic test_async_reset;
        int gc, bad;
        req = 2'b01;
        @(negedge clk);
        load_words(16, 32'h600, 2'b01, gc);
        req = 2'b00;
        repeat (50) @(negedge clk);
        checks++;
        if (!mod_int) begin errors++; $display("FAIL ar_pre: got mod_int=%b exp 1", mod_int); end
        rst_n = 1'b0;
        req = 2'b10;
        #1;
        checks++;
        if (ctrl !== 13'h008) begin errors++; $display("FAIL ar_ctrl: got %h exp %h", ctrl, 13'h008); end
        bad = 0;
        for (int k = 0; k < 16; k++) if (mod_data[k] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ar_moddata: got %0d nonzero words exp 0", bad); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, req_done, req_err} !== 6'b100000) begin
            errors++; $display("FAIL ar_grant10: got %b exp 100000", {gnt, req_done, req_err});
        end
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL ar_grant11: got %b exp 01", gnt); end
        req = 2'b00;
        rst_n = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_round_robin;
        test_stale_done;
        test_load_abort;
        test_tx_timeout;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
